// File: rtl/systolic_ws_sequencer_pkg.sv
// Shared types and timing helpers for the weight-stationary systolic sequencer.
package systolic_seq_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_WT, STREAM, DRAIN, DONE} state_t;

  // Cycles from a vector's first skewed element entering row 0 to its aligned write.
  function automatic int drain_len(int rows, int cols, int pipe_lat);
    return rows + cols - 1 + pipe_lat;
  endfunction

endpackage

// File: rtl/systolic_ws_sequencer_if.sv
// Control, buffer and array-edge signals of the systolic sequencer.
interface systolic_ws_sequencer_if #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16,
  parameter int MAX_VEC   = 16
);
  logic                          start;
  logic [$clog2(MAX_VEC):0]      num_vec;
  logic                          busy;
  logic                          done;
  logic                          wt_rd_en;
  logic [$clog2(ROWS)-1:0]       wt_rd_addr;
  logic [COLS*WORD_SIZE-1:0]     wt_rd_data;
  logic                          act_rd_en;
  logic [$clog2(MAX_VEC)-1:0]    act_rd_addr;
  logic [ROWS*WORD_SIZE-1:0]     act_rd_data;
  logic                          set_stationary;
  logic                          fsm_out_select_in;
  logic [COLS*WORD_SIZE-1:0]     top_in_bus;
  logic [ROWS*WORD_SIZE-1:0]     left_in_bus;
  logic [COLS*WORD_SIZE-1:0]     bottom_out;
  logic                          res_wr_en;
  logic [$clog2(MAX_VEC)-1:0]    res_wr_addr;
  logic [COLS*WORD_SIZE-1:0]     res_wr_data;

  modport master (
    input  start, num_vec, wt_rd_data, act_rd_data, bottom_out,
    output busy, done, wt_rd_en, wt_rd_addr, act_rd_en, act_rd_addr,
           set_stationary, fsm_out_select_in, top_in_bus, left_in_bus,
           res_wr_en, res_wr_addr, res_wr_data
  );

  modport slave (
    output start, num_vec, wt_rd_data, act_rd_data, bottom_out,
    input  busy, done, wt_rd_en, wt_rd_addr, act_rd_en, act_rd_addr,
           set_stationary, fsm_out_select_in, top_in_bus, left_in_bus,
           res_wr_en, res_wr_addr, res_wr_data
  );
endinterface

// File: rtl/systolic_ws_sequencer_skew_line.sv
// Zero-filled word delay line; DEPTH 0 is a plain wire.
module skew_line #(
  parameter int DEPTH     = 1,
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] din,
  output logic [WORD_SIZE-1:0] dout
);
  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
    end else begin : g_dly
      logic [DEPTH-1:0][WORD_SIZE-1:0] sr;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sr <= '0;
        end else begin
          sr[0] <= din;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end
      assign dout = sr[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/systolic_ws_sequencer.sv
// Weight-stationary array sequencer: weight load, skewed activation stream, de-skewed result writes.
module systolic_ws_sequencer
  import systolic_seq_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16,
  parameter int MAX_VEC   = 16,
  parameter int PIPE_LAT  = 1
) (
  input logic clk,
  input logic rst,
  systolic_ws_sequencer_if.master bus
);
  localparam int S_I  = ROWS + 2;
  localparam int W0_I = S_I + drain_len(ROWS, COLS, PIPE_LAT);
  localparam int CW   = $clog2(W0_I + MAX_VEC + 1) + 1;
  localparam int NVW  = $clog2(MAX_VEC) + 1;
  localparam int AW   = $clog2(MAX_VEC);
  localparam int WA   = $clog2(ROWS);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_ROWS = CW'(ROWS);
  localparam logic [CW-1:0] C_S    = CW'(S_I);
  localparam logic [CW-1:0] C_W0   = CW'(W0_I);

  state_t                          state, state_nx;
  logic [CW-1:0]                   cyc, nv;
  logic                            set_q, act_vld_q;
  logic [COLS-1:0][WORD_SIZE-1:0]  desk, res_q;

  // cyc tracks the job cycle number: 1 on the first cycle after start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cyc       <= '0;
      nv        <= '0;
      set_q     <= 1'b0;
      act_vld_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state     <= state_nx;
      cyc       <= (state == IDLE) ? C_ONE : cyc + C_ONE;
      if (state == IDLE && bus.start)
        nv <= (bus.num_vec > NVW'(MAX_VEC)) ? CW'(MAX_VEC) : CW'(bus.num_vec);
      set_q     <= bus.wt_rd_en;
      act_vld_q <= bus.act_rd_en;
      res_q     <= desk;
    end
  end

  always_comb begin
    state_nx              = state;
    bus.busy              = 1'b0;
    bus.done              = 1'b0;
    bus.wt_rd_en          = 1'b0;
    bus.wt_rd_addr        = '0;
    bus.act_rd_en         = 1'b0;
    bus.act_rd_addr       = '0;
    bus.fsm_out_select_in = 1'b0;
    bus.res_wr_en         = 1'b0;
    bus.res_wr_addr       = '0;
    case (state)
      IDLE: if (bus.start) state_nx = (bus.num_vec == '0) ? DONE : LOAD_WT;
      LOAD_WT: begin
        bus.busy       = 1'b1;
        bus.wt_rd_en   = 1'b1;
        bus.wt_rd_addr = WA'(C_ROWS - cyc);
        if (cyc == C_ROWS) state_nx = STREAM;
      end
      STREAM: begin
        bus.busy        = 1'b1;
        bus.act_rd_en   = 1'b1;
        bus.act_rd_addr = AW'(cyc - C_ROWS - C_ONE);
        if (cyc == C_ROWS + nv) state_nx = DRAIN;
      end
      DRAIN: begin
        bus.busy = 1'b1;
        if (cyc == C_W0 + nv - C_ONE) state_nx = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Long jobs start writing while activations are still streaming.
    if (state == STREAM || state == DRAIN) begin
      bus.fsm_out_select_in = (cyc >= C_S);
      if (cyc >= C_W0) begin
        bus.res_wr_en   = 1'b1;
        bus.res_wr_addr = AW'(cyc - C_W0);
      end
    end
  end

  assign bus.set_stationary = set_q;
  assign bus.top_in_bus     = set_q ? bus.wt_rd_data : '0;
  assign bus.res_wr_data    = bus.res_wr_en ? res_q : '0;

  genvar g;
  generate
    for (g = 0; g < ROWS; g++) begin : g_skew
      skew_line #(.DEPTH(g), .WORD_SIZE(WORD_SIZE)) u_skew (
        .clk  (clk),
        .rst  (rst),
        .din  (act_vld_q ? bus.act_rd_data[g*WORD_SIZE +: WORD_SIZE] : '0),
        .dout (bus.left_in_bus[g*WORD_SIZE +: WORD_SIZE])
      );
    end
    for (g = 0; g < COLS; g++) begin : g_deskew
      skew_line #(.DEPTH(COLS-1-g), .WORD_SIZE(WORD_SIZE)) u_deskew (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.bottom_out[g*WORD_SIZE +: WORD_SIZE]),
        .dout (desk[g])
      );
    end
  endgenerate
endmodule

// File: tb/tb_systolic_ws_sequencer.sv
// Bench for systolic_ws_sequencer: buffer and array models plus a cycle-level expectation model.
module tb_systolic_ws_sequencer;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int WS = 16;
  localparam int MV = 16;
  localparam int PL = 1;
  localparam int S  = R + 2;
  localparam int W0 = S + R + C - 1 + PL;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_ws_sequencer_if #(.ROWS(R), .COLS(C), .WORD_SIZE(WS), .MAX_VEC(MV)) bus ();
  systolic_ws_sequencer #(.ROWS(R), .COLS(C), .WORD_SIZE(WS), .MAX_VEC(MV), .PIPE_LAT(PL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [WS-1:0] wm [R][C];
  logic [WS-1:0] am [MV][R];

  int checks = 0;
  int errors = 0;

  // Buffers with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.wt_rd_en)
      for (int c = 0; c < C; c++) bus.wt_rd_data[c*WS +: WS] <= wm[bus.wt_rd_addr][c];
    if (bus.act_rd_en)
      for (int r = 0; r < R; r++) bus.act_rd_data[r*WS +: WS] <= am[bus.act_rd_addr][r];
  end

  // Behavioural array: weights shift down, activations right, partial sums down.
  logic [WS-1:0] aw [R][C];
  logic [WS-1:0] aa [R][C];
  logic [WS-1:0] ap [R][C];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          aw[r][c] <= '0; aa[r][c] <= '0; ap[r][c] <= '0;
        end
    end else begin
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          if (bus.set_stationary)
            aw[r][c] <= (r == 0) ? bus.top_in_bus[c*WS +: WS] : aw[(r == 0) ? 0 : r-1][c];
          aa[r][c] <= (c == 0) ? bus.left_in_bus[r*WS +: WS] : aa[r][(c == 0) ? 0 : c-1];
          ap[r][c] <= WS'(((r == 0) ? 16'd0 : ap[(r == 0) ? 0 : r-1][c]) +
                          ((c == 0) ? bus.left_in_bus[r*WS +: WS] : aa[r][(c == 0) ? 0 : c-1]) * aw[r][c]);
        end
    end
  end
  always_comb
    for (int c = 0; c < C; c++) bus.bottom_out[c*WS +: WS] = ap[R-1][c];

  // Job model: cur is the job cycle number (cycle 0 = start sampled), -1 when idle.
  int cur = -1;
  int mnv = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) cur <= -1;
    else if (cur < 0) begin
      if (bus.start) begin
        cur <= 1;
        mnv <= (int'(bus.num_vec) > MV) ? MV : int'(bus.num_vec);
      end
    end else if (cur == ((mnv == 0) ? 1 : W0 + mnv)) cur <= -1;
    else cur <= cur + 1;
  end

  int wr_cnt, done_cnt, busy_cnt, rd_cnt, done_cyc, first_l0, first_l3;
  int log_cyc[$];
  logic [63:0] log_dat[$];
  logic [63:0] log_adr[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cur, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_row(input int m);
    logic [63:0] v;
    logic [WS-1:0] s;
    v = '0;
    for (int c = 0; c < C; c++) begin
      s = '0;
      for (int r = 0; r < R; r++) s = WS'(s + am[m][r] * wm[r][c]);
      v[c*WS +: WS] = s;
    end
    return v;
  endfunction

  task automatic check_cycle();
    int k, n, m;
    logic act, e_wen, e_set, e_aen, e_ren;
    logic [63:0] e_top, e_left;
    k = cur; n = mnv; act = (k >= 1) && (n > 0);
    e_wen = act && k <= R;
    e_set = act && k >= 2 && k <= R + 1;
    e_aen = act && k >= R + 1 && k <= R + n;
    e_ren = act && k >= W0 && k < W0 + n;
    e_top = '0; e_left = '0;
    if (e_set) for (int c = 0; c < C; c++) e_top[c*WS +: WS] = wm[R+1-k][c];
    if (act)
      for (int r = 0; r < R; r++) begin
        m = k - S - r;
        if (m >= 0 && m < n) e_left[r*WS +: WS] = am[m][r];
      end
    chk("busy", 64'(bus.busy), 64'(act && k < W0 + n));
    chk("done", 64'(bus.done), 64'((k >= 1) && ((n == 0) ? k == 1 : k == W0 + n)));
    chk("wt_rd_en", 64'(bus.wt_rd_en), 64'(e_wen));
    if (e_wen) chk("wt_rd_addr", 64'(bus.wt_rd_addr), 64'(R - k));
    chk("set_stationary", 64'(bus.set_stationary), 64'(e_set));
    chk("top_in_bus", 64'(bus.top_in_bus), e_top);
    chk("act_rd_en", 64'(bus.act_rd_en), 64'(e_aen));
    if (e_aen) chk("act_rd_addr", 64'(bus.act_rd_addr), 64'(k - R - 1));
    chk("left_in_bus", 64'(bus.left_in_bus), e_left);
    chk("fsm_out_select_in", 64'(bus.fsm_out_select_in), 64'(act && k >= S && k < W0 + n));
    chk("res_wr_en", 64'(bus.res_wr_en), 64'(e_ren));
    if (e_ren) begin
      chk("res_wr_addr", 64'(bus.res_wr_addr), 64'(k - W0));
      chk("res_wr_data", 64'(bus.res_wr_data), exp_row(k - W0));
    end
    if (bus.res_wr_en) begin
      wr_cnt++; log_cyc.push_back(k); log_dat.push_back(64'(bus.res_wr_data));
      log_adr.push_back(64'(bus.res_wr_addr));
    end
    if (bus.done) begin done_cnt++; done_cyc = k; end
    if (bus.busy) busy_cnt++;
    if (bus.wt_rd_en || bus.act_rd_en || bus.set_stationary || bus.res_wr_en) rd_cnt++;
    if (first_l0 < 0 && bus.left_in_bus[0 +: WS] != '0) first_l0 = k;
    if (first_l3 < 0 && bus.left_in_bus[3*WS +: WS] != '0) first_l3 = k;
  endtask

  always @(negedge clk) if (!rst) check_cycle();

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 0);
    chk({tag, "_done"}, 64'(bus.done), 0);
    chk({tag, "_wt"}, 64'({bus.wt_rd_en, bus.wt_rd_addr}), 0);
    chk({tag, "_act"}, 64'({bus.act_rd_en, bus.act_rd_addr}), 0);
    chk({tag, "_ctl"}, 64'({bus.set_stationary, bus.fsm_out_select_in}), 0);
    chk({tag, "_top"}, 64'(bus.top_in_bus), 0);
    chk({tag, "_left"}, 64'(bus.left_in_bus), 0);
    chk({tag, "_wr"}, 64'({bus.res_wr_en, bus.res_wr_addr}), 0);
    chk({tag, "_wr_data"}, 64'(bus.res_wr_data), 0);
  endtask

  task automatic clr_obs();
    wr_cnt = 0; done_cnt = 0; busy_cnt = 0; rd_cnt = 0; done_cyc = -1;
    first_l0 = -1; first_l3 = -1;
    log_cyc.delete(); log_dat.delete(); log_adr.delete();
  endtask

  task automatic hold_start(input int n, input int cycles);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num_vec = 5'(n);
    repeat (cycles) @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (cur >= 0 && t < 400) begin @(posedge clk); #1; t++; end
    checks++;
    if (cur >= 0) begin errors++; $display("FAIL wait_idle timeout got=busy exp=idle"); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int t;
    bus.start = 1'b0; bus.num_vec = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wm[r][c] = WS'(r*4 + c + 1);
    for (int m = 0; m < MV; m++)
      for (int r = 0; r < R; r++) am[m][r] = '0;
    am[0][0] = 1; am[0][1] = 1; am[0][3] = 1;
    am[1][0] = 2;
    #1 rst = 1'b1;
    #1 check_zero("reset");
    repeat (3) @(posedge clk);
    #1 check_zero("reset_hold");
    rst = 1'b0;

    // Two-vector job with hand-computed results and timing.
    clr_obs();
    hold_start(2, 1);
    wait_idle();
    chk("A_writes", 64'(wr_cnt), 2);
    chk("A_w0_cyc", 64'(log_cyc[0]), 14);
    chk("A_w1_cyc", 64'(log_cyc[1]), 15);
    chk("A_w0_data", log_dat[0], 64'h001c_0019_0016_0013);
    chk("A_w1_data", log_dat[1], 64'h0008_0006_0004_0002);
    chk("A_done_cyc", 64'(done_cyc), 16);
    chk("A_first_l0", 64'(first_l0), 6);
    chk("skew_r3_minus_r0", 64'(first_l3 - first_l0), 3);

    // Zero-length job.
    clr_obs();
    hold_start(0, 1);
    wait_idle();
    chk("Z_done_cyc", 64'(done_cyc), 1);
    chk("Z_dones", 64'(done_cnt), 1);
    chk("Z_busy_cycles", 64'(busy_cnt), 0);
    chk("Z_strobes", 64'(rd_cnt), 0);

    // start held through DONE: ignored there; held into IDLE: one restart.
    for (int m = 0; m < 3; m++)
      for (int r = 0; r < R; r++) am[m][r] = WS'(m + r + 1);
    clr_obs();
    hold_start(3, W0 + 3 + 1);
    wait_idle();
    chk("H1_writes", 64'(wr_cnt), 3);
    chk("H1_dones", 64'(done_cnt), 1);
    clr_obs();
    hold_start(3, W0 + 3 + 2);
    wait_idle();
    chk("H2_writes", 64'(wr_cnt), 6);
    chk("H2_dones", 64'(done_cnt), 2);

    // Reset in the middle of streaming, then a clean job.
    hold_start(4, 1);
    t = 0;
    while (cur != 8 && t < 100) begin @(posedge clk); #1; t++; end
    chk("mid_reached", 64'(cur), 8);
    #1 rst = 1'b1;
    #1 check_zero("mid_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clr_obs();
    hold_start(2, 1);
    wait_idle();
    chk("post_rst_writes", 64'(wr_cnt), 2);
    chk("post_rst_w0", log_dat[0], exp_row(0));

    // Full-length and clamped jobs.
    for (int m = 0; m < MV; m++)
      for (int r = 0; r < R; r++) am[m][r] = WS'(m*3 + r);
    clr_obs();
    hold_start(16, 1);
    wait_idle();
    chk("F_writes", 64'(wr_cnt), 16);
    chk("F_last_addr", log_adr[15], 15);
    chk("F_contiguous", 64'(log_cyc[15] - log_cyc[0]), 15);
    clr_obs();
    hold_start(20, 1);
    wait_idle();
    chk("clamp_writes", 64'(wr_cnt), 16);
    chk("clamp_done_cyc", 64'(done_cyc), W0 + 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
